multdiv_timing_monitor: RTL and testbench

MULTDIV_TIMING_MONITOR -- requirements
Module: multdiv_timing_monitor

---
 rtl/ibex_xif_pkg.sv | 23 ++
 rtl/multdiv_timing_monitor_if.sv | 16 +
 rtl/multdiv_timing_chan.sv | 142 ++++++++++++++
 rtl/multdiv_timing_monitor.sv | 60 ++++++
 tb/tb_multdiv_timing_monitor.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_xif_pkg.sv
// Shared types for the multdiv timing monitor: operator encoding, channel FSM
// states and the bit positions of the sticky error flags.
package ibex_xif_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        DIT_IDLE = 2'd0,
        DIT_BUSY = 2'd1,
        DIT_HOLD = 2'd2
    } dit_mon_state_e;

    localparam int ERR_MISMATCH = 0;
    localparam int ERR_TIMEOUT  = 1;
    localparam int ERR_PROTOCOL = 2;
    localparam int ERR_OVERFLOW = 3;

endpackage

// File: rtl/multdiv_timing_monitor_if.sv
// Per-channel operation handshake bundle observed by the timing monitor.
interface multdiv_timing_monitor_if #(
    parameter int NUM_CH = 1
);
    import ibex_xif_pkg::*;

    logic   [NUM_CH-1:0] start;
    md_op_e [NUM_CH-1:0] op;
    logic   [NUM_CH-1:0] dit;
    logic   [NUM_CH-1:0] valid;
    logic   [NUM_CH-1:0] ready;

    modport master (output start, op, dit, valid, ready);
    modport slave  (input  start, op, dit, valid, ready);

endinterface

// File: rtl/multdiv_timing_chan.sv
// One monitored multdiv channel: IDLE/BUSY/HOLD tracker, saturating latency
// counter, sticky error flags and a count of completed DIT-checked operations.
module multdiv_timing_chan
    import ibex_xif_pkg::*;
#(
    parameter int CH    = 0,
    parameter int CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    srst,
    multdiv_timing_monitor_if.slave hs,
    input  logic                    exact_mode,
    input  logic [CNT_W-1:0]        exp_lat,
    input  logic                    clr,
    output md_op_e                  op,
    output logic [CNT_W-1:0]        lat,
    output logic                    lat_valid,
    output logic [3:0]              err,
    output logic                    busy,
    output logic [15:0]             checked_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dit_mon_state_e   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] lat_reg, lat_next;
    md_op_e           op_reg, op_next;
    logic             dit_reg, dit_next;
    logic             lat_valid_reg, lat_valid_next;
    logic             to_fired_reg, to_fired_next;
    logic [3:0]       err_reg, err_next;
    logic [15:0]      checked_reg, checked_next;

    logic start, valid, ready, handshake, mismatch;

    assign start     = hs.start[CH];
    assign valid     = hs.valid[CH];
    assign ready     = hs.ready[CH];
    assign handshake = valid && ready;
    // exp_lat follows op_reg combinationally, so threshold changes apply at once.
    assign mismatch  = exact_mode ? (cnt_reg != exp_lat) : (cnt_reg > exp_lat);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        dit_next       = dit_reg;
        lat_next       = lat_reg;
        lat_valid_next = 1'b0;
        to_fired_next  = to_fired_reg;
        err_next       = clr ? 4'b0000 : err_reg;
        checked_next   = clr ? 16'h0000 : checked_reg;

        unique case (state_reg)
            DIT_IDLE: begin
                if (start) begin
                    op_next       = hs.op[CH];
                    dit_next      = hs.dit[CH];
                    cnt_next      = CNT_W'(1);
                    to_fired_next = 1'b0;
                    state_next    = DIT_BUSY;
                end else if (valid) begin
                    err_next[ERR_PROTOCOL] = 1'b1;
                end
            end
            DIT_BUSY: begin
                if (valid) begin
                    lat_next       = cnt_reg;
                    lat_valid_next = 1'b1;
                    if (dit_reg && mismatch)
                        err_next[ERR_MISMATCH] = 1'b1;
                    state_next = ready ? DIT_IDLE : DIT_HOLD;
                end else begin
                    if (cnt_reg == CNT_MAX)
                        err_next[ERR_OVERFLOW] = 1'b1;
                    else
                        cnt_next = cnt_reg + 1'b1;
                    if (dit_reg && !to_fired_reg && (cnt_reg == exp_lat)) begin
                        err_next[ERR_TIMEOUT] = 1'b1;
                        to_fired_next         = 1'b1;
                    end
                end
            end
            DIT_HOLD: begin
                if (!valid)
                    err_next[ERR_PROTOCOL] = 1'b1;
                if (handshake)
                    state_next = DIT_IDLE;
            end
            default: state_next = DIT_IDLE;
        endcase

        // Completion and back-to-back restart share the IDLE-returning handshake.
        if (state_reg != DIT_IDLE) begin
            if (handshake) begin
                if (dit_reg && (checked_next != 16'hFFFF))
                    checked_next = checked_next + 16'd1;
                if (start) begin
                    op_next       = hs.op[CH];
                    dit_next      = hs.dit[CH];
                    cnt_next      = CNT_W'(1);
                    to_fired_next = 1'b0;
                    state_next    = DIT_BUSY;
                end
            end else if (start) begin
                err_next[ERR_PROTOCOL] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg     <= DIT_IDLE;
            cnt_reg       <= '0;
            op_reg        <= MD_OP_MULL;
            dit_reg       <= 1'b0;
            lat_reg       <= '0;
            lat_valid_reg <= 1'b0;
            to_fired_reg  <= 1'b0;
            err_reg       <= 4'b0000;
            checked_reg   <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            dit_reg       <= dit_next;
            lat_reg       <= lat_next;
            lat_valid_reg <= lat_valid_next;
            to_fired_reg  <= to_fired_next;
            err_reg       <= err_next;
            checked_reg   <= checked_next;
        end
    end

    assign op          = op_reg;
    assign lat         = lat_reg;
    assign lat_valid   = lat_valid_reg;
    assign err         = err_reg;
    assign busy        = (state_reg != DIT_IDLE);
    assign checked_cnt = checked_reg;

endmodule

// File: rtl/multdiv_timing_monitor.sv
// Latency/protocol monitor for NUM_CH multdiv channels; each channel looks up
// its expected latency by the operator it captured at start.
module multdiv_timing_monitor
    import ibex_xif_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic   [NUM_CH-1:0]           start_i,
    input  md_op_e [NUM_CH-1:0]           op_i,
    input  logic   [NUM_CH-1:0]           dit_i,
    input  logic   [NUM_CH-1:0]           valid_i,
    input  logic   [NUM_CH-1:0]           ready_i,
    input  logic                          exact_mode_i,
    input  logic   [3:0][CNT_W-1:0]       exp_lat_i,
    input  logic                          clr_i,
    output logic   [NUM_CH-1:0][CNT_W-1:0] lat_o,
    output logic   [NUM_CH-1:0]           lat_valid_o,
    output logic   [NUM_CH-1:0][3:0]      err_o,
    output logic   [NUM_CH-1:0]           busy_o,
    output logic   [NUM_CH-1:0][15:0]     checked_cnt_o
);
    multdiv_timing_monitor_if #(.NUM_CH(NUM_CH)) hs ();

    assign hs.start = start_i;
    assign hs.op    = op_i;
    assign hs.dit   = dit_i;
    assign hs.valid = valid_i;
    assign hs.ready = ready_i;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            md_op_e           cur_op;
            logic [CNT_W-1:0] exp_sel;

            assign exp_sel = exp_lat_i[cur_op];

            multdiv_timing_chan #(
                .CH    (gi),
                .CNT_W (CNT_W)
            ) u_chan (
                .clk         (clk_i),
                .srst        (rst_i),
                .hs          (hs),
                .exact_mode  (exact_mode_i),
                .exp_lat     (exp_sel),
                .clr         (clr_i),
                .op          (cur_op),
                .lat         (lat_o[gi]),
                .lat_valid   (lat_valid_o[gi]),
                .err         (err_o[gi]),
                .busy        (busy_o[gi]),
                .checked_cnt (checked_cnt_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multdiv_timing_monitor.sv
// Bench for multdiv_timing_monitor: a 1-channel 6-bit instance checked through a
// latency/error scoreboard, and a 2-channel 4-bit instance for overflow/clear.
module tb_multdiv_timing_monitor;
    import ibex_xif_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] lat;
        logic [3:0] err;
    } exp_t;
    exp_t sb_q[$];

    // ---------------- DUT A: NUM_CH=1, CNT_W=6 ----------------
    multdiv_timing_monitor_if #(.NUM_CH(1)) bus_a ();
    logic            exact_a = 1'b1;
    logic [3:0][5:0] exp_a   = '0;
    logic            clr_a   = 1'b0;
    logic [0:0][5:0]  lat_a;
    logic [0:0]       lat_valid_a;
    logic [0:0][3:0]  err_a;
    logic [0:0]       busy_a;
    logic [0:0][15:0] checked_a;

    multdiv_timing_monitor #(.NUM_CH(1), .CNT_W(6)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .start_i(bus_a.start), .op_i(bus_a.op), .dit_i(bus_a.dit),
        .valid_i(bus_a.valid), .ready_i(bus_a.ready),
        .exact_mode_i(exact_a), .exp_lat_i(exp_a), .clr_i(clr_a),
        .lat_o(lat_a), .lat_valid_o(lat_valid_a), .err_o(err_a),
        .busy_o(busy_a), .checked_cnt_o(checked_a)
    );

    // ---------------- DUT B: NUM_CH=2, CNT_W=4 ----------------
    multdiv_timing_monitor_if #(.NUM_CH(2)) bus_b ();
    logic            clr_b = 1'b0;
    logic [3:0][3:0] exp_b = {4{4'd15}};
    logic [1:0][3:0]  lat_b;
    logic [1:0]       lat_valid_b;
    logic [1:0][3:0]  err_b;
    logic [1:0]       busy_b;
    logic [1:0][15:0] checked_b;

    multdiv_timing_monitor #(.NUM_CH(2), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .start_i(bus_b.start), .op_i(bus_b.op), .dit_i(bus_b.dit),
        .valid_i(bus_b.valid), .ready_i(bus_b.ready),
        .exact_mode_i(1'b1), .exp_lat_i(exp_b), .clr_i(clr_b),
        .lat_o(lat_b), .lat_valid_o(lat_valid_b), .err_o(err_b),
        .busy_o(busy_b), .checked_cnt_o(checked_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int lat, input logic [3:0] err);
        exp_t e;
        e.lat = 6'(lat);
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every latency pulse on DUT A is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && lat_valid_a[0]) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_lat", 32'(lat_a[0]), 32'(e.lat));
                chk("sb_err", 32'(err_a[0]), 32'(e.err));
                $display("txn lat=%0d err=%b (expected lat=%0d err=%b)", lat_a[0], err_a[0], e.lat, e.err);
            end
        end
    end

    // Start an op, raise valid when cnt reaches lat, hold ready low for rd cycles.
    task automatic op_a(input md_op_e op, input logic dit, input int lat, input int rd, input int to_at);
        bus_a.start[0] = 1'b1;
        bus_a.op[0]    = op;
        bus_a.dit[0]   = dit;
        step();
        bus_a.start[0] = 1'b0;
        for (int c = 1; c < lat; c++) begin
            if (c == to_at) chk("timeout_not_yet", 32'(err_a[0][ERR_TIMEOUT]), 32'd0);
            step();
            if (c == to_at) chk("timeout_set", 32'(err_a[0][ERR_TIMEOUT]), 32'd1);
        end
        bus_a.valid[0] = 1'b1;
        bus_a.ready[0] = (rd == 0);
        step();
        for (int r = 0; r < rd; r++) begin
            chk("hold_busy", 32'(busy_a[0]), 32'd1);
            if (r == rd - 1) bus_a.ready[0] = 1'b1;
            step();
        end
        bus_a.valid[0] = 1'b0;
        bus_a.ready[0] = 1'b0;
        step();
    endtask

    task automatic clr_pulse_a();
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
    endtask

    initial begin
        bus_a.start = '0; bus_a.op = '{default: MD_OP_MULL}; bus_a.dit = '0;
        bus_a.valid = '0; bus_a.ready = '0;
        bus_b.start = '0; bus_b.op = '{default: MD_OP_MULL}; bus_b.dit = '0;
        bus_b.valid = '0; bus_b.ready = '0;

        repeat (3) step();
        chk("rst_lat", 32'(lat_a[0]), 32'd0);
        chk("rst_lat_valid", 32'(lat_valid_a[0]), 32'd0);
        chk("rst_err", 32'(err_a[0]), 32'd0);
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_checked", 32'(checked_a[0]), 32'd0);
        rst = 1'b0;
        step();

        // MULL exact, expected 3, valid at 3 with ready
        exp_a[MD_OP_MULL] = 6'd3; exact_a = 1'b1;
        push(3, 4'b0000);
        op_a(MD_OP_MULL, 1'b1, 3, 0, 0);
        chk("mull_checked", 32'(checked_a[0]), 32'd1);
        chk("mull_idle", 32'(busy_a[0]), 32'd0);

        // DIV expected 37 arriving at 36: exact flags, at-most does not
        exp_a[MD_OP_DIV] = 6'd37;
        push(36, 4'b0001);
        op_a(MD_OP_DIV, 1'b1, 36, 0, 0);
        clr_pulse_a();
        chk("clr_err", 32'(err_a[0]), 32'd0);
        chk("clr_checked", 32'(checked_a[0]), 32'd0);
        exact_a = 1'b0;
        push(36, 4'b0000);
        op_a(MD_OP_DIV, 1'b1, 36, 0, 0);
        exact_a = 1'b1;

        // Timeout at 5, late valid at 8
        exp_a[MD_OP_REM] = 6'd5;
        push(8, 4'b0011);
        op_a(MD_OP_REM, 1'b1, 8, 0, 5);
        chk("timeout_checked", 32'(checked_a[0]), 32'd2);

        // Non-DIT op that would mismatch: no new flag, count unchanged
        push(10, 4'b0011);
        op_a(MD_OP_MULL, 1'b0, 10, 0, 0);
        chk("nondit_checked", 32'(checked_a[0]), 32'd2);
        clr_pulse_a();

        // HOLD with valid held through 3 ready-low cycles
        exp_a[MD_OP_MULL] = 6'd4;
        push(4, 4'b0000);
        op_a(MD_OP_MULL, 1'b1, 4, 3, 0);
        chk("hold_idle", 32'(busy_a[0]), 32'd0);
        chk("hold_err", 32'(err_a[0]), 32'd0);
        chk("hold_checked", 32'(checked_a[0]), 32'd1);

        // valid dropped while in HOLD
        push(4, 4'b0000);
        bus_a.start[0] = 1'b1; bus_a.op[0] = MD_OP_MULL; bus_a.dit[0] = 1'b1;
        step();
        bus_a.start[0] = 1'b0;
        repeat (3) step();
        bus_a.valid[0] = 1'b1; bus_a.ready[0] = 1'b0;
        step();
        bus_a.valid[0] = 1'b0;
        step();
        bus_a.valid[0] = 1'b1; bus_a.ready[0] = 1'b1;
        step();
        bus_a.valid[0] = 1'b0; bus_a.ready[0] = 1'b0;
        step();
        chk("hold_drop_protocol", 32'(err_a[0]), 32'b0100);
        clr_pulse_a();

        // Back-to-back restart, then stray start in BUSY must not change op
        exp_a[MD_OP_MULL] = 6'd2; exp_a[MD_OP_DIV] = 6'd3; exp_a[MD_OP_MULH] = 6'd9;
        push(2, 4'b0000);
        push(3, 4'b0100);
        bus_a.start[0] = 1'b1; bus_a.op[0] = MD_OP_MULL; bus_a.dit[0] = 1'b1;
        step();
        bus_a.start[0] = 1'b0;
        step();
        bus_a.valid[0] = 1'b1; bus_a.ready[0] = 1'b1;
        bus_a.start[0] = 1'b1; bus_a.op[0] = MD_OP_DIV;
        step();
        bus_a.valid[0] = 1'b0; bus_a.ready[0] = 1'b0; bus_a.start[0] = 1'b0;
        chk("b2b_busy", 32'(busy_a[0]), 32'd1);
        chk("b2b_no_protocol", 32'(err_a[0]), 32'd0);
        bus_a.start[0] = 1'b1; bus_a.op[0] = MD_OP_MULH;
        step();
        bus_a.start[0] = 1'b0;
        chk("busy_start_protocol", 32'(err_a[0]), 32'b0100);
        step();
        bus_a.valid[0] = 1'b1; bus_a.ready[0] = 1'b1;
        step();
        bus_a.valid[0] = 1'b0; bus_a.ready[0] = 1'b0;
        step();
        chk("b2b_checked", 32'(checked_a[0]), 32'd2);
        clr_pulse_a();

        // valid in IDLE
        bus_a.valid[0] = 1'b1;
        step();
        bus_a.valid[0] = 1'b0;
        chk("idle_valid_protocol", 32'(err_a[0]), 32'b0100);

        // Reset mid-operation aborts silently
        bus_a.start[0] = 1'b1; bus_a.op[0] = MD_OP_DIV;
        step();
        bus_a.start[0] = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_a[0]), 32'd0);
        chk("midrst_err", 32'(err_a[0]), 32'd0);
        chk("midrst_lat", 32'(lat_a[0]), 32'd0);
        chk("midrst_checked", 32'(checked_a[0]), 32'd0);
        step();

        // DUT B: ch0 runs 20 cycles on a 4-bit counter
        bus_b.start[0] = 1'b1; bus_b.op[0] = MD_OP_MULL; bus_b.dit[0] = 1'b0;
        step();
        bus_b.start[0] = 1'b0;
        for (int c = 1; c < 20; c++) step();
        bus_b.valid[0] = 1'b1; bus_b.ready[0] = 1'b1;
        step();
        bus_b.valid[0] = 1'b0; bus_b.ready[0] = 1'b0;
        chk("ovf_pulse_ch0", 32'(lat_valid_b[0]), 32'd1);
        chk("ovf_lat_ch0", 32'(lat_b[0]), 32'd15);
        chk("ovf_err_ch0", 32'(err_b[0]), 32'b1000);
        chk("ovf_pulse_ch1", 32'(lat_valid_b[1]), 32'd0);
        chk("ovf_err_ch1", 32'(err_b[1]), 32'd0);
        $display("txn ch0 lat=%0d err=%b ch1 err=%b", lat_b[0], err_b[0], err_b[1]);
        // clear coinciding with a fresh ch1 protocol error
        clr_b = 1'b1; bus_b.valid[1] = 1'b1;
        step();
        clr_b = 1'b0; bus_b.valid[1] = 1'b0;
        chk("clr_ch0_cleared", 32'(err_b[0]), 32'd0);
        chk("clr_ch1_kept", 32'(err_b[1]), 32'b0100);

        repeat (3) step();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
